nios2_computer_mem_test_master: RTL and testbench
=================================================

Name: nios2_computer_mem_test_master

Overview:
Avalon-MM initiator that drives the single-port on-chip RAM slave (word address, 4-bit byteenable, chipselect/write, fixed read latency, no waitrequest) from the memory side's opposite end. On a start command it fills a region with a generated pattern, verifies it, or does both. It reports busy, done and an error count. It sits between a control source (PIO or test bench) and the on-chip memory s1 port.

Parameters:
ADDR_W, 14, word-address width of the memory port
DATA_W, 32, data width; byteenable width is DATA_W/8
MEM_WORDS, 10240, memory depth; addresses wrap to 0 after MEM_WORDS-1
READ_LATENCY, 1, cycles from read address to valid readdata (1 or 2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
mode  in  2  0=fill, 1=verify, 2=fill then verify, 3=reserved (treated as fill)
base_addr  in  ADDR_W  first word address
word_count  in  ADDR_W+1  words to access (0..MEM_WORDS)
seed  in  DATA_W  pattern seed
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at completion
err_count  out  16  mismatches in the last verify; saturates at 16'hFFFF
first_err_addr  out  ADDR_W  address of the first mismatch
address  out  ADDR_W  master address
byteenable  out  DATA_W/8  all ones during any access
chipselect  out  1  access strobe
write  out  1  write qualifier
writedata  out  DATA_W  pattern word
clken  out  1  memory clock enable; high while busy
readdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, reset_n=0): FSM->IDLE. busy, done, chipselect, write, clken = 0. address, writedata, err_count, first_err_addr = 0. byteenable = 0. Any in-progress sequence is aborted with no done pulse.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: on start=1, latch base_addr, word_count, seed and mode. err_count and first_err_addr clear only when a verify phase will run.
  - word_count=0: go to DONE; no accesses.
  - mode 0/2/3: go to WRITE.
  - mode 1: go to READ.
- WRITE: one write per cycle, no stalls. chipselect=1, write=1, byteenable all ones.
  - address = (base+i) mod MEM_WORDS; writedata = pattern(i), for i = 0..N-1.
  - After the last word: mode 2 goes to READ in the next cycle with i reset to 0; otherwise go to DONE.
- READ: one read address per cycle (chipselect=1, write=0). Expected data pattern(i) and the address are delayed READ_LATENCY cycles alongside a valid bit.
- DRAIN: hold for READ_LATENCY cycles after the last read address, then go to DONE.
- Compare: happens whenever the delayed valid bit is 1.
  - On mismatch: err_count increments, saturating.
  - On the first mismatch of the run: first_err_addr captures the delayed address.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then return to IDLE.
- Timing (start high in cycle 0):
  - Fill of N words: accesses in cycles 1..N, done in cycle N+1.
  - Verify of N words: addresses in cycles 1..N, done in cycle N+1+READ_LATENCY.
  - Mode 2: writes in cycles 1..N, reads in cycles N+1..2N.
- Address wrap: the increment from MEM_WORDS-1 goes to 0, not 2^ADDR_W. base_addr >= MEM_WORDS is reduced modulo MEM_WORDS. word_count > MEM_WORDS is clamped to MEM_WORDS.
- start while busy is ignored. start in the DONE cycle is ignored.
- Outside WRITE/READ: chipselect=0, write=0, byteenable=0. clken=1 in WRITE, READ and DRAIN.
- Default pattern: pattern(i) = seed + i, modulo 2^DATA_W.

Optional Feature:
MEM_TEST_LFSR_EN: when defined, the pattern is a 32-bit Galois LFSR with taps 0x80200003.
- The LFSR is loaded with seed; a seed of 0 is replaced by 32'h1.
- It advances once per accessed word. Verify reloads the seed so it regenerates the identical sequence.
- When undefined, the incrementing pattern seed+i is used and no LFSR logic is synthesised.

Test Plan:
- Fill, mode=0, base=0, N=4, seed=32'h100 -> writes 100,101,102,103 at addresses 0..3 in cycles 1..4; done pulse in cycle 5; err_count=0.
- Mode=2, base=10, N=8, clean memory model -> 8 writes then 8 reads; done at cycle 18 (READ_LATENCY=1); err_count=0.
- Same as previous, with the model corrupting the word at address 13 -> err_count=1, first_err_addr=13.
- Wrap, mode=0, base=10238, N=4 -> addresses 10238, 10239, 0, 1; no address ≥ 10240 is issued.
- word_count=0 -> no chipselect; done in cycle 1. start pulsed during busy -> ignored, counts unchanged.
- reset_n low mid-WRITE at i=3 -> outputs zero asynchronously; no done pulse; a new start afterwards runs normally.

Source files
------------

// File: rtl/nios2_computer_mem_test_master.sv
// Avalon-MM memory test initiator: fills a region with a pattern, verifies it, or both.
// Define MEM_TEST_LFSR_EN to use a 32-bit Galois LFSR pattern instead of seed+i.
module nios2_computer_mem_test_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int MEM_WORDS    = 10240,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic                  clken,
  input  logic [DATA_W-1:0]     readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
  localparam logic [ADDR_W:0]   MAX_N     = (ADDR_W+1)'(MEM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d, ferr_q, ferr_d;
  logic [ADDR_W:0]     rem_q, rem_d, n_q, n_d;
  logic [DATA_W-1:0]   pat_q, pat_d, seed_q, seed_d;
  logic [1:0]          mode_q, mode_d, drain_q, drain_d;
  logic [15:0]         err_q, err_d;
  logic                vld_q  [READ_LATENCY];
  logic                vld_d  [READ_LATENCY];
  logic [DATA_W-1:0]   exp_q  [READ_LATENCY];
  logic [DATA_W-1:0]   exp_d  [READ_LATENCY];
  logic [ADDR_W-1:0]   eadr_q [READ_LATENCY];
  logic [ADDR_W-1:0]   eadr_d [READ_LATENCY];
  logic [ADDR_W:0]     n_clamp;
  logic [ADDR_W-1:0]   base_mod;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

`ifdef MEM_TEST_LFSR_EN
  function automatic logic [DATA_W-1:0] pat_first(input logic [DATA_W-1:0] s);
    return (s == '0) ? DATA_W'(1) : s;
  endfunction
  function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
    return (p >> 1) ^ (p[0] ? DATA_W'(32'h8020_0003) : '0);
  endfunction
`else
  function automatic logic [DATA_W-1:0] pat_first(input logic [DATA_W-1:0] s);
    return s;
  endfunction
  function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
    return p + 1'b1;
  endfunction
`endif

  assign n_clamp  = (word_count > MAX_N) ? MAX_N : word_count;
  assign base_mod = ADDR_W'(32'(base_addr) % 32'(MEM_WORDS));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    rem_d   = rem_q;
    n_d     = n_q;
    pat_d   = pat_q;
    seed_d  = seed_q;
    mode_d  = mode_q;
    drain_d = drain_q;
    err_d   = err_q;
    ferr_d  = ferr_q;

    // Expected data and address travel with the read so the compare lines up with readdata.
    vld_d[0]  = (state_q == S_READ);
    exp_d[0]  = pat_q;
    eadr_d[0] = addr_q;
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_d[k]  = vld_q[k-1];
      exp_d[k]  = exp_q[k-1];
      eadr_d[k] = eadr_q[k-1];
    end

    if (vld_q[READ_LATENCY-1] && (readdata != exp_q[READ_LATENCY-1])) begin
      if (err_q == 16'd0) ferr_d = eadr_q[READ_LATENCY-1];
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_mod;
          addr_d = base_mod;
          n_d    = n_clamp;
          rem_d  = n_clamp;
          seed_d = seed;
          pat_d  = pat_first(seed);
          mode_d = mode;
          if ((mode == 2'd1 || mode == 2'd2) && n_clamp != '0) begin
            err_d  = '0;
            ferr_d = '0;
          end
          if (n_clamp == '0)      state_d = S_DONE;
          else if (mode == 2'd1)  state_d = S_READ;
          else                    state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_inc(addr_q);
        pat_d  = pat_next(pat_q);
        rem_d  = rem_q - 1'b1;
        if (rem_q == (ADDR_W+1)'(1)) begin
          if (mode_q == 2'd2) begin
            state_d = S_READ;
            addr_d  = base_q;
            pat_d   = pat_first(seed_q);
            rem_d   = n_q;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        addr_d = addr_inc(addr_q);
        pat_d  = pat_next(pat_q);
        rem_d  = rem_q - 1'b1;
        if (rem_q == (ADDR_W+1)'(1)) begin
          state_d = S_DRAIN;
          drain_d = 2'(READ_LATENCY - 1);
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) state_d = S_DONE;
        else                 drain_d = drain_q - 2'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      rem_q   <= '0;
      n_q     <= '0;
      pat_q   <= '0;
      seed_q  <= '0;
      mode_q  <= '0;
      drain_q <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        vld_q[k]  <= 1'b0;
        exp_q[k]  <= '0;
        eadr_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      n_q     <= n_d;
      pat_q   <= pat_d;
      seed_q  <= seed_d;
      mode_q  <= mode_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      for (int k = 0; k < READ_LATENCY; k++) begin
        vld_q[k]  <= vld_d[k];
        exp_q[k]  <= exp_d[k];
        eadr_q[k] <= eadr_d[k];
      end
    end
  end

  assign chipselect     = (state_q == S_WRITE) || (state_q == S_READ);
  assign write          = (state_q == S_WRITE);
  assign byteenable     = chipselect ? {BE_W{1'b1}} : '0;
  assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign clken          = busy;
  assign done           = (state_q == S_DONE);
  assign address        = addr_q;
  assign writedata      = pat_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_nios2_computer_mem_test_master.sv
// Randomized bench for nios2_computer_mem_test_master against a transaction-level reference model.
module tb_nios2_computer_mem_test_master;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int MW     = 10240;
  localparam int RL     = 1;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [1:0]          mode = '0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W:0]     word_count = '0;
  logic [DATA_W-1:0]   seed = '0;
  logic                busy, done, chipselect, write, clken;
  logic [15:0]         err_count;
  logic [ADDR_W-1:0]   first_err_addr, address;
  logic [3:0]          byteenable;
  logic [DATA_W-1:0]   writedata, readdata, rdata;

  logic [31:0] mem     [MW];
  logic [31:0] ref_mem [MW];
  int corrupt_addr = -1;
  int n_checks = 0;
  int n_errors = 0;
  int exp_err  = 0;
  int exp_ferr = 0;

  always #5 clk = ~clk;

  nios2_computer_mem_test_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write), .writedata(writedata), .clken(clken),
    .readdata(readdata)
  );

  // On-chip RAM model with one cycle read latency; one word can be forced to read back wrong.
  always @(posedge clk) begin
    if (chipselect && int'(address) < MW) begin
      if (write) mem[address] <= writedata;
      else       rdata <= mem[address] ^ ((int'(address) == corrupt_addr) ? 32'h1 : 32'h0);
    end
  end
  assign readdata = rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] pat_first(input logic [31:0] s);
`ifdef MEM_TEST_LFSR_EN
    return (s == 32'd0) ? 32'd1 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] pat_next(input logic [31:0] p);
`ifdef MEM_TEST_LFSR_EN
    return (p >> 1) ^ (p[0] ? 32'h8020_0003 : 32'h0);
`else
    return p + 32'd1;
`endif
  endfunction

  task automatic run_cmd(input logic [1:0] m, input int base, input int cnt, input logic [31:0] sd,
                         input int corrupt, input bit poke_busy, input bit poke_done);
    int exp_cyc[$];
    bit exp_wr[$];
    int exp_ad[$];
    logic [31:0] exp_wd[$];
    int n, b, a, off, done_cyc, idx;
    bit got_done;
    logic [31:0] p, rv;
    n = (cnt > MW) ? MW : cnt;
    b = base % MW;
    corrupt_addr = corrupt;
    p = pat_first(sd);
    if (m != 2'd1) begin
      for (int i = 0; i < n; i++) begin
        a = (b + i) % MW;
        exp_cyc.push_back(i + 1); exp_wr.push_back(1'b1); exp_ad.push_back(a); exp_wd.push_back(p);
        ref_mem[a] = p;
        p = pat_next(p);
      end
    end
    if ((m == 2'd1 || m == 2'd2) && n > 0) begin
      exp_err = 0; exp_ferr = 0;
      off = (m == 2'd2) ? n : 0;
      p = pat_first(sd);
      for (int i = 0; i < n; i++) begin
        a = (b + i) % MW;
        exp_cyc.push_back(off + i + 1); exp_wr.push_back(1'b0); exp_ad.push_back(a); exp_wd.push_back(32'h0);
        rv = ref_mem[a] ^ ((a == corrupt) ? 32'h1 : 32'h0);
        if (rv != p) begin
          if (exp_err == 0) exp_ferr = a;
          if (exp_err < 65535) exp_err++;
        end
        p = pat_next(p);
      end
    end
    if (n == 0)          done_cyc = 1;
    else if (m == 2'd1)  done_cyc = n + 1 + RL;
    else if (m == 2'd2)  done_cyc = 2 * n + 1 + RL;
    else                 done_cyc = n + 1;

    @(negedge clk);
    start = 1'b1; mode = m; base_addr = ADDR_W'(base); word_count = (ADDR_W+1)'(cnt); seed = sd;
    @(posedge clk);
    idx = 0; got_done = 1'b0;
    for (int c = 1; c <= done_cyc + 5 && !got_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (chipselect) begin
        chk("addr_range", 64'(int'(address) < MW), 1);
        chk("byteenable", byteenable, 4'hF);
        if (idx < exp_cyc.size()) begin
          chk("acc_cycle", c, exp_cyc[idx]);
          chk("acc_write", write, exp_wr[idx]);
          chk("acc_addr", address, exp_ad[idx]);
          if (exp_wr[idx]) chk("acc_wdata", writedata, exp_wd[idx]);
        end
        idx++;
      end
      if (done) begin
        chk("done_cycle", c, done_cyc);
        chk("busy_at_done", busy, 0);
        got_done = 1'b1;
        if (poke_done) start = 1'b1;
      end else begin
        chk("busy", busy, 64'(c < done_cyc));
        chk("clken", clken, 64'(c < done_cyc));
        if (poke_busy && c == 1) begin
          start = 1'b1; mode = 2'd1; base_addr = '0; word_count = 15'd3; seed = 32'hDEAD;
        end
      end
    end
    chk("done_seen", got_done, 1);
    chk("access_count", idx, exp_cyc.size());
    @(negedge clk);
    start = 1'b0;
    chk("err_count", err_count, exp_err);
    chk("first_err_addr", first_err_addr, exp_ferr);
    if (poke_done) begin
      for (int k = 0; k < 3; k++) begin
        chk("idle_after_done_cs", chipselect, 0);
        chk("idle_after_done_busy", busy, 0);
        @(negedge clk);
      end
    end
    corrupt_addr = -1;
  endtask

  task automatic reset_mid_write(input logic [31:0] sd);
    logic [31:0] p;
    @(negedge clk);
    start = 1'b1; mode = 2'd0; base_addr = '0; word_count = 15'd10; seed = sd;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_addr", address, 3);
    reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cs", chipselect, 0);
    chk("rst_write", write, 0);
    chk("rst_clken", clken, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ferr", first_err_addr, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    reset_n = 1'b1;
    // Words 0..2 were committed before reset hit during the fourth write.
    p = pat_first(sd);
    for (int i = 0; i < 3; i++) begin
      ref_mem[i] = p;
      p = pat_next(p);
    end
    exp_err = 0; exp_ferr = 0;
  endtask

  initial begin
    for (int i = 0; i < MW; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err_count, 0);
    reset_n = 1'b1;

    run_cmd(2'd0, 0, 4, 32'h100, -1, 1'b0, 1'b0);
    run_cmd(2'd2, 10, 8, $urandom, -1, 1'b0, 1'b0);
    run_cmd(2'd2, 10, 8, $urandom, 13, 1'b0, 1'b0);
    run_cmd(2'd0, 10238, 4, $urandom, -1, 1'b0, 1'b0);
    run_cmd(2'd0, 100, 0, $urandom, -1, 1'b0, 1'b1);
    run_cmd(2'd0, 200, 6, $urandom, -1, 1'b1, 1'b1);
    run_cmd(2'd1, 200, 6, 32'd0, -1, 1'b1, 1'b0);
    reset_mid_write($urandom);
    run_cmd(2'd2, 0, 5, $urandom, 2, 1'b0, 1'b0);
    run_cmd(2'd3, 16000, 7, $urandom, -1, 1'b0, 1'b0);
    run_cmd(2'd1, 300, 20, $urandom, -1, 1'b0, 1'b0);
    run_cmd(2'd0, 5000, 12000, $urandom, -1, 1'b0, 1'b0);
    run_cmd(2'd1, 10230, 20, $urandom, -1, 1'b0, 1'b0);
    for (int t = 0; t < 12; t++) begin
      int cor, bs;
      bs  = int'($urandom_range(0, 16383));
      cor = ($urandom_range(0, 1) == 1) ? (bs % MW) + int'($urandom_range(0, 3)) : -1;
      run_cmd(2'($urandom_range(0, 3)), bs, int'($urandom_range(1, 40)), $urandom, cor % MW,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
